// File: rtl/exec_wb_collector_if.sv
// Handshake bundle between the execute-result producer, the collector queue and the write-back consumer.
interface exec_wb_collector_if #(
  parameter int LANES   = 7,
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 16,
  parameter int OUT_NUM = 2
);
  logic [LANES-1:0]           in_valid;
  logic [LANES*ENTRY_W-1:0]   in_data;
  logic                       in_ready;
  logic [OUT_NUM-1:0]         out_valid;
  logic [OUT_NUM*ENTRY_W-1:0] out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/exec_wb_collector.sv
// In-order circular queue gathering per-FU commit records and draining OUT_NUM per cycle to write-back.
// Optional stall counter port is enabled by defining EXEC_WB_STALL_STATS_EN.

// Simulation-only invariants of the collector queue.
module exec_wb_collector_chk #(
  parameter int DEPTH   = 16,
  parameter int OUT_NUM = 2,
  parameter int CNT_W   = 5,
  parameter int LCW     = 3
) (
  input logic               clk,
  input logic               resetn,
  input logic [CNT_W-1:0]   count,
  input logic [LCW-1:0]     push_cnt,
  input logic [OUT_NUM-1:0] out_valid
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    (32'(count) + 32'(push_cnt)) <= 32'(DEPTH));

  a_valid_contig: assert property (@(posedge clk) disable iff (!resetn)
    (out_valid & (out_valid + OUT_NUM'(1))) == OUT_NUM'(0));
endmodule

module exec_wb_collector #(
  parameter int LANES   = 7,
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 16,
  parameter int OUT_NUM = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
`ifdef EXEC_WB_STALL_STATS_EN
  output logic [31:0]         stall_cycles,
`endif
  exec_wb_collector_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LCW   = $clog2(LANES + 1);

  function automatic logic [LCW-1:0] popcount_f(input logic [LANES-1:0] vec);
    logic [LCW-1:0] cnt;
    cnt = LCW'(0);
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + LCW'(vec[i]);
    end
    return cnt;
  endfunction

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;

  logic               in_ready_s;
  logic [LCW-1:0]     push_cnt_s;
  logic [CNT_W-1:0]   pop_cnt_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [LCW-1:0]     offset_s [LANES];

  // Accept decision looks only at registered occupancy, so out_ready never reaches in_ready.
  assign in_ready_s = (count_r <= CNT_W'(DEPTH - LANES));

  // Push/pop amounts and next occupancy.
  always_comb begin
    push_cnt_s   = LCW'(0);
    pop_cnt_s    = CNT_W'(0);
    count_next_s = count_r;
    if (in_ready_s) begin
      push_cnt_s = popcount_f(bus.in_valid);
    end else begin
      push_cnt_s = LCW'(0);
    end
    if (bus.out_ready) begin
      if (count_r >= CNT_W'(OUT_NUM)) begin
        pop_cnt_s = CNT_W'(OUT_NUM);
      end else begin
        pop_cnt_s = count_r;
      end
    end else begin
      pop_cnt_s = CNT_W'(0);
    end
    count_next_s = count_r + CNT_W'(push_cnt_s) - pop_cnt_s;
  end

  // Compaction: each valid lane lands after all valid lanes below it.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      offset_s[i] = popcount_f(bus.in_valid & ((LANES'(1) << i) - LANES'(1)));
    end
  end

  // Queue storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (in_ready_s && !flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.in_valid[i]) begin
          mem_r[tail_r + PTR_W'(offset_s[i])] <= bus.in_data[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  // Pointer and occupancy state; flush wins over push and pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else if (flush) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else begin
      head_r  <= head_r + PTR_W'(pop_cnt_s);
      tail_r  <= tail_r + PTR_W'(push_cnt_s);
      count_r <= count_next_s;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.count    = count_r;

  for (genvar g = 0; g < OUT_NUM; g++) begin : g_slot
    assign bus.out_valid[g]                  = (count_r > CNT_W'(g));
    assign bus.out_data[g*ENTRY_W +: ENTRY_W] = mem_r[head_r + PTR_W'(g)];
  end

`ifdef EXEC_WB_STALL_STATS_EN
  // Saturating count of cycles where the producer offered work but was refused.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= 32'd0;
    end else if ((|bus.in_valid) && !in_ready_s && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end
`else
  // Without stall statistics the queue carries no extra state.
`endif

`ifndef SYNTHESIS
  exec_wb_collector_chk #(
    .DEPTH   (DEPTH),
    .OUT_NUM (OUT_NUM),
    .CNT_W   (CNT_W),
    .LCW     (LCW)
  ) u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .count     (count_r),
    .push_cnt  (push_cnt_s),
    .out_valid (bus.out_valid)
  );
`endif
endmodule

// File: tb/tb_exec_wb_collector.sv
// Randomised and directed bench for exec_wb_collector against a queue-based reference model.
module tb_exec_wb_collector;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
`ifdef EXEC_WB_STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] stall_m = 32'd0;
`endif

  exec_wb_collector_if #(.LANES(7), .ENTRY_W(64), .DEPTH(16), .OUT_NUM(2)) bus ();

  exec_wb_collector #(.LANES(7), .ENTRY_W(64), .DEPTH(16), .OUT_NUM(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
`ifdef EXEC_WB_STALL_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  logic [63:0] q[$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [4:0] m_count();
    return 5'(q.size());
  endfunction

  function automatic logic m_ready();
    return (16 - q.size()) >= 7;
  endfunction

  function automatic logic [1:0] m_valid();
    logic [1:0] v;
    for (int i = 0; i < 2; i++) v[i] = (q.size() > i);
    return v;
  endfunction

  function automatic logic [127:0] m_mask();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) if (q.size() > i) r[i*64 +: 64] = '1;
    return r;
  endfunction

  function automatic logic [127:0] m_data();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) if (q.size() > i) r[i*64 +: 64] = q[i];
    return r;
  endfunction

  function automatic logic [447:0] rand_bundle();
    logic [447:0] d;
    for (int i = 0; i < 7; i++) d[i*64 +: 64] = {$urandom(), $urandom()};
    return d;
  endfunction

  // One clock of stimulus; the model applies the same cycle rules at a queue level.
  task automatic step(input logic [6:0] v, input logic [447:0] d, input logic ordy, input logic fl);
    bit acc;
    int n;
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = ordy;
    flush = fl;
    acc = m_ready();
`ifdef EXEC_WB_STALL_STATS_EN
    if (v != 7'd0 && !acc && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
    if (fl) q.delete();
    else begin
      if (ordy) begin
        n = (q.size() < 2) ? q.size() : 2;
        repeat (n) void'(q.pop_front());
      end
      if (acc) for (int i = 0; i < 7; i++) if (v[i]) q.push_back(d[i*64 +: 64]);
    end
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    resetn = 1'b0;
    q.delete();
`ifdef EXEC_WB_STALL_STATS_EN
    stall_m = 32'd0;
`endif
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (bus.count !== 5'd0 || bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset: count=%0d valid=%b rdy=%b, want 0/00/1", bus.count, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic_order();
    logic [447:0] d;
    d = '0;
    d[0 +: 64] = 64'hA0;
    d[128 +: 64] = 64'hA2;
    step(7'b0000101, d, 1'b1, 1'b0);
    nvec++;
    if (bus.count !== 5'd2 || bus.out_valid !== 2'b11 || bus.out_data !== {64'hA2, 64'hA0}) begin
      nerr++;
      $display("FAIL basic_order: count=%0d valid=%b data=%h, want 2/11/%h", bus.count, bus.out_valid, bus.out_data, {64'hA2, 64'hA0});
    end
    step(7'd0, '0, 1'b1, 1'b0);
    nvec++;
    if (bus.count !== 5'd0 || bus.out_valid !== 2'b00) begin
      nerr++;
      $display("FAIL basic_drain: count=%0d valid=%b, want 0/00", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_fill_stall();
    logic [447:0] d;
    for (int k = 0; k < 3; k++) begin
      d = rand_bundle();
      step(7'h7F, d, 1'b0, 1'b0);
    end
    nvec++;
    if (bus.count !== 5'd14 || bus.in_ready !== 1'b0 || m_count() !== 5'd14) begin
      nerr++;
      $display("FAIL fill_stall: count=%0d rdy=%b, want 14/0", bus.count, bus.in_ready);
    end
  endtask

  task automatic test_drain_wrap();
    for (int k = 0; k < 7; k++) begin
      step(7'd0, '0, 1'b1, 1'b0);
      nvec++;
      if (bus.count !== 5'(12 - 2*k) || bus.out_valid !== m_valid() || (bus.out_data & m_mask()) !== m_data()) begin
        nerr++;
        $display("FAIL drain k=%0d: count=%0d valid=%b data=%h, want %0d/%b/%h", k, bus.count, bus.out_valid, bus.out_data & m_mask(), 12 - 2*k, m_valid(), m_data());
      end
    end
    step(7'h7F, rand_bundle(), 1'b0, 1'b0);
    step(7'h7F, rand_bundle(), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (bus.count !== m_count() || bus.out_valid !== m_valid() || bus.in_ready !== m_ready() || (bus.out_data & m_mask()) !== m_data()) begin
        nerr++;
        $display("FAIL wrap k=%0d: count=%0d valid=%b rdy=%b data=%h, want %0d/%b/%b/%h", k, bus.count, bus.out_valid, bus.in_ready, bus.out_data & m_mask(), m_count(), m_valid(), m_ready(), m_data());
      end
      step(7'd0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [447:0] d;
    d = '0;
    d[0 +: 64] = 64'hC0;
    step(7'b0000001, d, 1'b0, 1'b0);
    d = '0;
    d[0 +: 64] = 64'hC1;
    d[192 +: 64] = 64'hC2;
    d[384 +: 64] = 64'hC3;
    step(7'b1001001, d, 1'b1, 1'b0);
    nvec++;
    if (bus.count !== 5'd3 || bus.out_data !== {64'hC2, 64'hC1} || (bus.out_data & m_mask()) !== m_data()) begin
      nerr++;
      $display("FAIL simul_push_pop: count=%0d data=%h, want 3/%h", bus.count, bus.out_data, {64'hC2, 64'hC1});
    end
    for (int k = 0; k < 3; k++) step(7'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    logic [447:0] d;
    step(7'h7F, rand_bundle(), 1'b0, 1'b0);
    step(7'b0000011, rand_bundle(), 1'b0, 1'b0);
    d = '0;
    for (int i = 0; i < 4; i++) d[i*64 +: 64] = 64'hF0 + 64'(i);
    nvec++;
    if (bus.count !== 5'd9 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL flush_setup: count=%0d rdy=%b, want 9/1", bus.count, bus.in_ready);
    end
    step(7'b0001111, d, 1'b1, 1'b1);
    nvec++;
    if (bus.count !== 5'd0 || bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL flush: count=%0d valid=%b rdy=%b, want 0/00/1", bus.count, bus.out_valid, bus.in_ready);
    end
    d = '0;
    d[0 +: 64] = 64'hE0;
    step(7'b0000001, d, 1'b0, 1'b0);
    nvec++;
    if (bus.count !== 5'd1 || bus.out_valid !== 2'b01 || bus.out_data[63:0] !== 64'hE0) begin
      nerr++;
      $display("FAIL flush_after: count=%0d valid=%b slot0=%h, want 1/01/e0", bus.count, bus.out_valid, bus.out_data[63:0]);
    end
    step(7'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] v;
    logic [447:0] d;
    bit held;
    held = 1'b0;
    v = '0;
    d = '0;
    for (int k = 0; k < 400; k++) begin
      if (!held) begin
        v = 7'($urandom_range(0, 127));
        d = rand_bundle();
      end
      held = (v != 7'd0) && !m_ready();
      step(v, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      nvec++;
      if (bus.count !== m_count() || bus.out_valid !== m_valid() || bus.in_ready !== m_ready() || (bus.out_data & m_mask()) !== m_data()) begin
        nerr++;
        $display("FAIL random k=%0d: count=%0d valid=%b rdy=%b data=%h, want %0d/%b/%b/%h", k, bus.count, bus.out_valid, bus.in_ready, bus.out_data & m_mask(), m_count(), m_valid(), m_ready(), m_data());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(7'h7F, rand_bundle(), 1'b0, 1'b0);
    step(7'h7F, rand_bundle(), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(7'h7F, rand_bundle(), 1'b0, 1'b0);
    step(7'd0, '0, 1'b0, 1'b1);
    step(7'b0011111, rand_bundle(), 1'b0, 1'b0);
    nvec++;
    if (bus.count !== 5'd5 || (bus.out_data & m_mask()) !== m_data()) begin
      nerr++;
      $display("FAIL async_setup: count=%0d, want 5", bus.count);
    end
`ifdef EXEC_WB_STALL_STATS_EN
    nvec++;
    if (stall_cycles !== 32'd3 || stall_m !== 32'd3) begin
      nerr++;
      $display("FAIL stall_before: stall_cycles=%0d, want 3", stall_cycles);
    end
`endif
    #2;
    resetn = 1'b0;
    q.delete();
#1;
    nvec++;
    if (bus.count !== 5'd0 || bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL async_reset: count=%0d valid=%b rdy=%b, want 0/00/1", bus.count, bus.out_valid, bus.in_ready);
    end
`ifdef EXEC_WB_STALL_STATS_EN
    stall_m = 32'd0;
    nvec++;
    if (stall_cycles !== 32'd0) begin
      nerr++;
      $display("FAIL stall_after: stall_cycles=%0d, want 0", stall_cycles);
    end
`endif
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step(7'b0000010, rand_bundle(), 1'b0, 1'b0);
    nvec++;
    if (bus.count !== m_count() || (bus.out_data & m_mask()) !== m_data()) begin
      nerr++;
      $display("FAIL post_reset: count=%0d data=%h, want %0d/%h", bus.count, bus.out_data & m_mask(), m_count(), m_data());
    end
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_order();
    test_fill_stall();
    test_drain_wrap();
    test_simul_push_pop();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
